// File: rtl/instr_queue_pkg.sv
// Shared constants for the instruction queue.
// Defaults, opcode encodings and the pointer-width rule.
package instr_queue_pkg;

  localparam int IQ_WIDTH = 16;
  localparam int IQ_DEPTH = 4;
  localparam int IQ_OP_W  = 4;

  typedef enum logic [3:0] {
    MOV_LD = 4'h0,
    MOV_ST = 4'h1,
    ADD    = 4'h2,
    LDC    = 4'h3,
    SUB    = 4'h4,
    JMPZ   = 4'h5
  } opcode_e;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int IQ_PTR_W = ptr_w(IQ_DEPTH);

endpackage

// File: rtl/instr_queue_mem.sv
// Instruction queue storage: DEPTH x WIDTH registers.
// Synchronous write, asynchronous read, no reset.
module instr_queue_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write port: only an accepted push stores a word
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_queue.sv
// Circular instruction queue between fetch and the controller.
// Optional macro IRQ_BYPASS_EN: empty-queue in-to-out bypass.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int WIDTH = IQ_WIDTH,
  parameter int DEPTH = IQ_DEPTH,
  parameter int OP_W  = IQ_OP_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [OP_W-1:0]            out_op,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [AW-1:0] P_ONE = AW'(1);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] rd_data;
  logic             stored;
  logic             bypass;
  logic             push;
  logic             pop;

  assign stored   = (count != '0);
  assign in_ready = (count != FULL);

`ifdef IRQ_BYPASS_EN
  assign bypass = !stored && !flush && in_valid;
`else
  assign bypass = 1'b0;
`endif

  // a bypassed word taken the same cycle is never stored
  assign push = in_valid && in_ready
                && !(bypass && out_ready);
  assign pop  = stored && out_ready;

  assign out_valid = stored || bypass;
  assign out_op    = out_data[WIDTH-1 -: OP_W];

  // head word: bypass, stored head, or zeros
  always_comb begin
    out_data = '0;
    if (bypass)      out_data = in_data;
    else if (stored) out_data = rd_data;
  end

  // pointers and occupancy; flush wins over push/pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop)  rd_ptr <= rd_ptr + P_ONE;
      unique case ({push, pop})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
    end
  end

  instr_queue_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (push && !flush),
    .waddr(wr_ptr),
    .wdata(in_data),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue.
// Random traffic against a queue-based reference model.
module tb_instr_queue;

`ifdef IRQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int QD = 4;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_op;
  logic [2:0]  count;

  int checks;
  int errors;

  logic [15:0] mq[$];

  instr_queue dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_op   (out_op),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit          byp;
    logic [15:0] ed;
    byp = BYP && mq.size() == 0 && !flush && in_valid;
    if (byp)                ed = in_data;
    else if (mq.size() > 0) ed = mq[0];
    else                    ed = 16'h0000;
    chk("count", 32'(count), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() != QD));
    chk("out_valid", 32'(out_valid), 32'(byp || mq.size() > 0));
    chk("out_data", 32'(out_data), 32'(ed));
    chk("out_op", 32'(out_op), 32'(ed >> 12));
  endtask

  task automatic model_edge();
    bit pp;
    bit pu;
    if (flush) begin
      mq.delete();
    end else if (BYP && mq.size() == 0
                 && in_valid && out_ready) begin
      // consumed via bypass, never stored
    end else begin
      pp = out_ready && mq.size() > 0;
      pu = in_valid && mq.size() < QD;
      if (pp) void'(mq.pop_front());
      if (pu) mq.push_back(in_data);
    end
  endtask

  task automatic step(input logic f, input logic iv,
                      input logic orr, input logic [15:0] d);
    flush     = f;
    in_valid  = iv;
    out_ready = orr;
    in_data   = d;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  logic [15:0] seq [4];

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 16'h0000;
    seq[0] = 16'h1234;
    seq[1] = 16'h3001;
    seq[2] = 16'h5A02;
    seq[3] = 16'h2103;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_ready", 32'(in_ready), 1);
    reset = 1'b0;

    // reset mid-stream with three words queued
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, seq[i]);
    chk("pre_rst_count", 32'(count), 3);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    mq.delete();
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data", 32'(out_data), 0);
    chk("arst_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // fill, refuse overflow, drain, twice for wrap
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++)
        step(1'b0, 1'b1, 1'b0, seq[i]);
      chk("full_count", 32'(count), 4);
      chk("full_ready", 32'(in_ready), 0);
      chk("full_op", 32'(out_op), 32'h1);
      step(1'b0, 1'b1, 1'b0, 16'hFFFF);
      chk("ovf_count", 32'(count), 4);
      chk("ovf_head", 32'(out_data), 32'h1234);
      for (int i = 0; i < 4; i++) begin
        chk("drain", 32'(out_data), 32'(seq[i]));
        step(1'b0, 1'b0, 1'b1, 16'h0000);
      end
      chk("empty_valid", 32'(out_valid), 0);
      chk("empty_count", 32'(count), 0);
    end

    // steady push+pop at count 2
    step(1'b0, 1'b1, 1'b0, 16'hA000);
    step(1'b0, 1'b1, 1'b0, 16'hA001);
    for (int i = 0; i < 6; i++) begin
      chk("pp_count", 32'(count), 2);
      chk("pp_order", 32'(out_data), 32'(16'hA000 + i));
      step(1'b0, 1'b1, 1'b1, 16'(16'hA002 + i));
    end
    chk("pp_count_end", 32'(count), 2);

    // flush at count 3 with push and pop
    step(1'b0, 1'b1, 1'b0, 16'hB000);
    chk("pre_fl_count", 32'(count), 3);
    step(1'b1, 1'b1, 1'b1, 16'hBEEF);
    chk("fl_count", 32'(count), 0);
    chk("fl_valid", 32'(out_valid), 0);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("fl_no_word", 32'(out_valid), 0);

    // empty queue, push and pop together
    flush     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 16'h4005;
    #1;
    chk("byp_valid", 32'(out_valid), 32'(BYP));
    chk("byp_data", 32'(out_data),
        BYP ? 32'h4005 : 32'h0);
    @(posedge clk);
    model_edge();
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("byp_count", 32'(count), BYP ? 0 : 1);
    chk("byp_next", 32'(out_data),
        BYP ? 32'h0 : 32'h4005);
    step(1'b0, 1'b0, 1'b1, 16'h0000);

    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(15) == 0,
           $urandom_range(9) < 6,
           $urandom_range(1) == 1,
           16'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
